crc5_arbiter: RTL and testbench



---
 rtl/crc5_arbiter_if.sv | 24 ++
 rtl/crc5_arbiter.sv | 129 ++++++++++++
 tb/tb_crc5_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/crc5_arbiter_if.sv
// Request/response bundle between the two token requesters and the shared CRC5 engine.
interface crc5_arbiter_if;
    logic [1:0]  req_valid;
    logic [10:0] req_field0;
    logic [10:0] req_field1;
    logic [4:0]  req_crc0;
    logic [4:0]  req_crc1;
    logic [1:0]  req_ready;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [4:0]  crc_out;
    logic        crc_match;

    modport master (
        output req_valid, req_field0, req_field1, req_crc0, req_crc1,
        input  req_ready, busy, done, done_id, crc_out, crc_match
    );

    modport slave (
        input  req_valid, req_field0, req_field1, req_crc0, req_crc1,
        output req_ready, busy, done, done_id, crc_out, crc_match
    );
endinterface

// File: rtl/crc5_arbiter.sv
// Shared bit-serial USB token CRC5 engine serving a TX builder (0) and RX checker (1).
// Define CRC5_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module crc5_arbiter (
    input  logic               clk,
    input  logic               rst,
    crc5_arbiter_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [10:0] field_reg, field_next;
    logic [4:0]  exp_reg, exp_next;
    logic        id_reg, id_next;
    logic [4:0]  lfsr_reg, lfsr_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [4:0]  crc_reg, crc_next;
    logic        match_reg, match_next;
    logic        done_id_reg, done_id_next;
    logic        grant_valid;
    logic        grant_id;
    logic        fb;
    logic [4:0]  lfsr_shift;
`ifdef CRC5_RR_EN
    logic        last_reg, last_next;
`endif

    always_comb begin
        grant_valid = (state_reg == IDLE) && (bus.req_valid != 2'b00) && !rst;
`ifdef CRC5_RR_EN
        // Under contention favour whoever lost last time.
        if (&bus.req_valid)
            grant_id = ~last_reg;
        else
            grant_id = ~bus.req_valid[0];
`else
        grant_id = ~bus.req_valid[0];
`endif
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    // x^5 + x^2 + 1, field bits enter LSB first.
    assign fb         = lfsr_reg[4] ^ field_reg[cnt_reg];
    assign lfsr_shift = {lfsr_reg[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);

    always_comb begin
        state_next   = state_reg;
        field_next   = field_reg;
        exp_next     = exp_reg;
        id_next      = id_reg;
        lfsr_next    = lfsr_reg;
        cnt_next     = cnt_reg;
        crc_next     = crc_reg;
        match_next   = match_reg;
        done_id_next = done_id_reg;
`ifdef CRC5_RR_EN
        last_next    = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    field_next = grant_id ? bus.req_field1 : bus.req_field0;
                    exp_next   = grant_id ? bus.req_crc1 : bus.req_crc0;
                    id_next    = grant_id;
                    lfsr_next  = 5'b11111;
                    cnt_next   = 4'd0;
                    state_next = SHIFT;
`ifdef CRC5_RR_EN
                    last_next  = grant_id;
`endif
                end
            end
            SHIFT: begin
                lfsr_next = lfsr_shift;
                if (cnt_reg == 4'd10) begin
                    // Results are captured on entry to DONE so they are valid alongside done.
                    state_next   = DONE;
                    crc_next     = ~lfsr_shift;
                    match_next   = (~lfsr_shift == exp_reg);
                    done_id_next = id_reg;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            field_reg   <= 11'd0;
            exp_reg     <= 5'd0;
            id_reg      <= 1'b0;
            lfsr_reg    <= 5'd0;
            cnt_reg     <= 4'd0;
            crc_reg     <= 5'd0;
            match_reg   <= 1'b0;
            done_id_reg <= 1'b0;
`ifdef CRC5_RR_EN
            last_reg    <= 1'b1;
`endif
        end else begin
            state_reg   <= state_next;
            field_reg   <= field_next;
            exp_reg     <= exp_next;
            id_reg      <= id_next;
            lfsr_reg    <= lfsr_next;
            cnt_reg     <= cnt_next;
            crc_reg     <= crc_next;
            match_reg   <= match_next;
            done_id_reg <= done_id_next;
`ifdef CRC5_RR_EN
            last_reg    <= last_next;
`endif
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.done_id   = done_id_reg;
    assign bus.crc_out   = crc_reg;
    assign bus.crc_match = match_reg;
endmodule

// File: tb/tb_crc5_arbiter.sv
// Directed and random checks of crc5_arbiter against a polynomial-division CRC5 reference.
module tb_crc5_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc5_arbiter_if bus ();
    crc5_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Preset-to-ones is equivalent to inverting the first five message bits before division.
    function automatic logic [4:0] ref_crc5(input logic [10:0] f);
        logic [15:0] v;
        v = 16'd0;
        for (int i = 0; i < 11; i++) v[15-i] = f[i] ^ (i < 5);
        for (int k = 15; k >= 5; k--)
            if (v[k]) v = v ^ (16'h0025 << (k - 5));
        return ~v[4:0];
    endfunction

    task automatic run_txn(input logic [1:0] valid, input logic [10:0] f0, input logic [10:0] f1,
                           input logic [4:0] c0, input logic [4:0] c1, input bit hold,
                           input logic [10:0] f0_after,
                           output logic [1:0] ready_seen, output int wait_cyc, output int lat,
                           output logic [4:0] crc, output logic match, output logic id);
        bus.req_valid  = valid;
        bus.req_field0 = f0;
        bus.req_field1 = f1;
        bus.req_crc0   = c0;
        bus.req_crc1   = c1;
        ready_seen = 2'b00;
        wait_cyc   = 0;
        lat        = 0;
        crc        = 5'd0;
        match      = 1'b0;
        id         = 1'b0;
        while (wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
            if (bus.req_ready != 2'b00) break;
        end
        ready_seen = bus.req_ready;
        check("grant_seen", 32'(ready_seen != 2'b00), 32'd1);
        if (ready_seen == 2'b00) return;
        @(posedge clk);
        #1;
        bus.req_field0 = f0_after;
        if (!hold) bus.req_valid = valid & ~ready_seen;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.done) break;
        end
        crc   = bus.crc_out;
        match = bus.crc_match;
        id    = bus.done_id;
        $display("txn valid=%b ready=%b latency=%0d crc=%b match=%b id=%b", valid, ready_seen, lat, crc, match, id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rdy;
        logic [1:0]  exp_rdy;
        int          wc, lat, dones;
        logic [4:0]  crc, c;
        logic        m, id, r;
        logic [10:0] f, g;

        rst = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_field0 = 11'd0;
        bus.req_field1 = 11'd0;
        bus.req_crc0   = 5'd0;
        bus.req_crc1   = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);
        check("rst_crc", 32'(bus.crc_out), 32'd0);
        check("rst_match", 32'(bus.crc_match), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero field on the transmit side
        run_txn(2'b01, 11'h000, 11'h000, 5'b01000, 5'b00000, 1'b0, 11'h000, rdy, wc, lat, crc, m, id);
        check("zero_ready", 32'(rdy), 32'(2'b01));
        check("zero_latency", 32'(lat), 32'd12);
        check("zero_crc", 32'(crc), 32'(5'b01000));
        check("zero_id", 32'(id), 32'd0);
        check("zero_match", 32'(m), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_crc_hold", 32'(bus.crc_out), 32'(5'b01000));
        @(posedge clk);
        #1;

        // Receiver check, matching then mismatching expected CRC
        run_txn(2'b10, 11'h000, 11'h000, 5'b00000, 5'b01000, 1'b0, 11'h000, rdy, wc, lat, crc, m, id);
        check("rx_ready", 32'(rdy), 32'(2'b10));
        check("rx_latency", 32'(lat), 32'd12);
        check("rx_match", 32'(m), 32'd1);
        check("rx_id", 32'(id), 32'd1);
        run_txn(2'b10, 11'h000, 11'h000, 5'b00000, 5'b01001, 1'b0, 11'h000, rdy, wc, lat, crc, m, id);
        check("rx_nomatch", 32'(m), 32'd0);
        check("rx_nomatch_crc", 32'(crc), 32'(5'b01000));

        // Field change after grant must not affect the result
        run_txn(2'b01, 11'h000, 11'h000, 5'b00000, 5'b00000, 1'b0, 11'h7FF, rdy, wc, lat, crc, m, id);
        check("latch_crc", 32'(crc), 32'(5'b01000));
        check("latch_id", 32'(id), 32'd0);

        // All-ones field on the receive side
        run_txn(2'b10, 11'h000, 11'h7FF, 5'b00000, ref_crc5(11'h7FF), 1'b0, 11'h000, rdy, wc, lat, crc, m, id);
        check("ones_crc", 32'(crc), 32'(ref_crc5(11'h7FF)));
        check("ones_match", 32'(m), 32'd1);

        // Reset in the middle of SHIFT
        bus.req_field0 = 11'h123;
        bus.req_valid  = 2'b01;
        wc = 0;
        while (wc < 20) begin
            @(negedge clk);
            wc++;
            if (bus.req_ready != 2'b00) break;
        end
        check("abort_ready", 32'(bus.req_ready), 32'(2'b01));
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_crc", 32'(bus.crc_out), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_match", 32'(bus.crc_match), 32'd0);
        check("abort_ready_low", 32'(bus.req_ready), 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        @(posedge clk);
        #1;

        // Contention with both requesters holding valid
        f = 11'h2A5;
        g = 11'h15A;
        for (int k = 0; k < 3; k++) begin
            run_txn(2'b11, f, g, 5'b00000, 5'b00000, 1'b1, f, rdy, wc, lat, crc, m, id);
`ifdef CRC5_RR_EN
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
            check("cont_ready", 32'(rdy), 32'(exp_rdy));
            check("cont_wait", 32'(wc), 32'd1);
            check("cont_latency", 32'(lat), 32'd12);
            check("cont_crc", 32'(crc), 32'(ref_crc5(exp_rdy[1] ? g : f)));
            check("cont_id", 32'(id), 32'(exp_rdy[1]));
        end
        bus.req_valid = 2'b00;

        // Random sweep against the reference model
        for (int k = 0; k < 1000; k++) begin
            r = 1'($urandom_range(0, 1));
            f = 11'($urandom);
            g = 11'($urandom);
            c = ($urandom_range(0, 1) != 0) ? ref_crc5(f) : 5'($urandom);
            if (r)
                run_txn(2'b10, g, f, 5'd0, c, 1'b0, g, rdy, wc, lat, crc, m, id);
            else
                run_txn(2'b01, f, g, c, 5'd0, 1'b0, f, rdy, wc, lat, crc, m, id);
            check("sweep_ready", 32'(rdy), r ? 32'd2 : 32'd1);
            check("sweep_latency", 32'(lat), 32'd12);
            check("sweep_crc", 32'(crc), 32'(ref_crc5(f)));
            check("sweep_match", 32'(m), 32'(ref_crc5(f) == c));
            check("sweep_id", 32'(id), 32'(r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
